// File: rtl/bullet_hit_detect.sv
// Bullet hit detector: checks each sampled bullet position against screen bounds, enemy box and wall map.
// Latency: 3 cycles from sample (IDLE) to registered des_bullet/hit_tank; explosion_flag held EXPL_CYCLES.
// Backpressure: none; the bullet mover must drop bullet_act after des_bullet before a new pass starts.
module bullet_hit_detect #(
  parameter int H_MAX       = 640,
  parameter int V_MAX       = 480,
  parameter int TANK_SIZE   = 32,
  parameter int EXPL_CYCLES = 2500000
) (
  input  logic       clk25,
  input  logic       reset,
  input  logic       bullet_act,
  input  logic [9:0] bullet_x,
  input  logic [8:0] bullet_y,
  input  logic [9:0] enemy_x,
  input  logic [8:0] enemy_y,
  output logic [8:0] map_addr,
  input  logic       map_data,
  output logic       des_bullet,
  output logic       explosion_flag,
  output logic [9:0] expl_x,
  output logic [8:0] expl_y,
  output logic       hit_tank
);

  localparam int CNT_W = (EXPL_CYCLES > 1) ? $clog2(EXPL_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXPL_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EVAL  = 3'd2,
    EXPL  = 3'd3,
    CLEAR = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [9:0]       bx_q, bx_d;
  logic [8:0]       by_q, by_d;
  logic [8:0]       map_addr_q, map_addr_d;
  logic             des_bullet_q, des_bullet_d;
  logic             hit_tank_q, hit_tank_d;
  logic             explosion_flag_q, explosion_flag_d;
  logic [9:0]       expl_x_q, expl_x_d;
  logic [8:0]       expl_y_q, expl_y_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Hit tests on the latched position; widened by one bit so the tank box end never wraps.
  logic [10:0] bx_w, ex_lo, ex_hi;
  logic [9:0]  by_w, ey_lo, ey_hi;
  logic        oob, in_tank;

  assign bx_w    = {1'b0, bx_q};
  assign by_w    = {1'b0, by_q};
  assign ex_lo   = {1'b0, enemy_x};
  assign ey_lo   = {1'b0, enemy_y};
  assign ex_hi   = ex_lo + 11'(TANK_SIZE - 1);
  assign ey_hi   = ey_lo + 10'(TANK_SIZE - 1);
  assign oob     = (bx_w >= 11'(H_MAX)) || (by_w >= 10'(V_MAX));
  assign in_tank = (bx_w >= ex_lo) && (bx_w <= ex_hi) && (by_w >= ey_lo) && (by_w <= ey_hi);

  // Next-state and next-output logic; pulses default low so they last exactly one cycle.
  always_comb begin
    state_d          = state_q;
    bx_d             = bx_q;
    by_d             = by_q;
    map_addr_d       = map_addr_q;
    des_bullet_d     = 1'b0;
    hit_tank_d       = 1'b0;
    explosion_flag_d = explosion_flag_q;
    expl_x_d         = expl_x_q;
    expl_y_d         = expl_y_q;
    cnt_d            = cnt_q;
    case (state_q)
      IDLE: begin
        if (bullet_act) begin
          bx_d       = bullet_x;
          by_d       = bullet_y;
          map_addr_d = {bullet_y[8:5], bullet_x[9:5]};
          state_d    = FETCH;
        end
      end
      FETCH: begin
        // Sync ROM needs this cycle to return the wall bit.
        state_d = bullet_act ? EVAL : IDLE;
      end
      EVAL: begin
        if (!bullet_act) begin
          state_d = IDLE;
        end else if (oob) begin
          des_bullet_d = 1'b1;
          state_d      = CLEAR;
        end else if (in_tank) begin
          des_bullet_d     = 1'b1;
          hit_tank_d       = 1'b1;
          expl_x_d         = bx_q;
          expl_y_d         = by_q;
          explosion_flag_d = 1'b1;
          cnt_d            = '0;
          state_d          = EXPL;
        end else if (map_data) begin
          des_bullet_d     = 1'b1;
          expl_x_d         = bx_q;
          expl_y_d         = by_q;
          explosion_flag_d = 1'b1;
          cnt_d            = '0;
          state_d          = EXPL;
        end else begin
          state_d = IDLE;
        end
      end
      EXPL: begin
        // Flag was raised on entry, so it stays high for exactly EXPL_CYCLES cycles.
        if (cnt_q == CNT_LAST) begin
          explosion_flag_d = 1'b0;
          cnt_d            = '0;
          state_d          = CLEAR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEAR: begin
        // Hold off new passes until the mover retires the killed bullet.
        if (!bullet_act) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      state_q          <= IDLE;
      bx_q             <= '0;
      by_q             <= '0;
      map_addr_q       <= '0;
      des_bullet_q     <= 1'b0;
      hit_tank_q       <= 1'b0;
      explosion_flag_q <= 1'b0;
      expl_x_q         <= '0;
      expl_y_q         <= '0;
      cnt_q            <= '0;
    end else begin
      state_q          <= state_d;
      bx_q             <= bx_d;
      by_q             <= by_d;
      map_addr_q       <= map_addr_d;
      des_bullet_q     <= des_bullet_d;
      hit_tank_q       <= hit_tank_d;
      explosion_flag_q <= explosion_flag_d;
      expl_x_q         <= expl_x_d;
      expl_y_q         <= expl_y_d;
      cnt_q            <= cnt_d;
    end
  end

  assign map_addr       = map_addr_q;
  assign des_bullet     = des_bullet_q;
  assign hit_tank       = hit_tank_q;
  assign explosion_flag = explosion_flag_q;
  assign expl_x         = expl_x_q;
  assign expl_y         = expl_y_q;

endmodule

// File: tb/tb_bullet_hit_detect.sv
// Bench for bullet_hit_detect: shots are classified by a rule-level reference model and queued.
// A negedge monitor pops expected kills when des_bullet appears and tracks explosion length.
// Wall map is a sync ROM model feeding map_data one cycle after map_addr.
`timescale 1ns/1ps
module tb_bullet_hit_detect;
  localparam int EXPL_N = 16;
  localparam int K_NONE = 0;
  localparam int K_OOB  = 1;
  localparam int K_TANK = 2;
  localparam int K_WALL = 3;

  logic       clk25 = 1'b0;
  logic       reset = 1'b1;
  logic       bullet_act = 1'b0;
  logic [9:0] bullet_x = '0;
  logic [8:0] bullet_y = '0;
  logic [9:0] enemy_x = '0;
  logic [8:0] enemy_y = '0;
  logic [8:0] map_addr;
  logic       map_data = 1'b0;
  logic       des_bullet;
  logic       explosion_flag;
  logic [9:0] expl_x;
  logic [8:0] expl_y;
  logic       hit_tank;

  bullet_hit_detect #(
    .H_MAX(640), .V_MAX(480), .TANK_SIZE(32), .EXPL_CYCLES(EXPL_N)
  ) dut (
    .clk25(clk25), .reset(reset), .bullet_act(bullet_act),
    .bullet_x(bullet_x), .bullet_y(bullet_y),
    .enemy_x(enemy_x), .enemy_y(enemy_y),
    .map_addr(map_addr), .map_data(map_data),
    .des_bullet(des_bullet), .explosion_flag(explosion_flag),
    .expl_x(expl_x), .expl_y(expl_y), .hit_tank(hit_tank)
  );

  always #20 clk25 = ~clk25;

  int cyc = 0;
  always @(posedge clk25) cyc <= cyc + 1;

  bit wall [512];
  always @(posedge clk25) map_data <= wall[map_addr];

  typedef struct {
    int due;
    bit tank;
    bit explode;
    int x;
    int y;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference rules: bounds first, then enemy box, then wall tile.
  function automatic int classify(input int x, input int y, input int ex, input int ey);
    logic [8:0] idx;
    if (x >= 640 || y >= 480) return K_OOB;
    if (x >= ex && x <= ex + 31 && y >= ey && y <= ey + 31) return K_TANK;
    idx = 9'((y / 32) * 32 + x / 32);
    if (wall[idx]) return K_WALL;
    return K_NONE;
  endfunction

  // Monitor: consumes expected kills, times them, and measures explosions.
  bit in_expl = 1'b0;
  bit armed = 1'b0;
  int run = 0;
  always @(negedge clk25) begin
    if (reset) begin
      in_expl = 1'b0;
      armed = 1'b0;
      run = 0;
    end else begin
      if (des_bullet) begin
        if (sb.size() == 0) begin
          check("spurious_des", 1, 0);
        end else begin
          m_e = sb.pop_front();
          check("des_cycle", cyc, m_e.due);
          check("hit_tank", int'(hit_tank), int'(m_e.tank));
          check("expl_start", int'(explosion_flag), int'(m_e.explode));
          if (m_e.explode) begin
            check("expl_x", int'(expl_x), m_e.x);
            check("expl_y", int'(expl_y), m_e.y);
            armed = 1'b1;
          end
        end
      end else begin
        check("hit_without_des", int'(hit_tank), 0);
        if (sb.size() > 0 && sb[0].due < cyc) begin
          check("missing_des", 0, 1);
          m_e = sb.pop_front();
        end
      end
      if (explosion_flag && !in_expl) begin
        check("expl_has_hit", int'(armed), 1);
        in_expl = 1'b1;
        run = 1;
      end else if (explosion_flag) begin
        run++;
      end else if (in_expl) begin
        check("expl_len", run, EXPL_N);
        in_expl = 1'b0;
        armed = 1'b0;
      end
    end
  end

  task automatic shot(input int x, input int y, input int ex, input int ey,
                      input int hold, input bit abort);
    int k;
    int kind;
    @(negedge clk25);
    bullet_x = 10'(x);
    bullet_y = 9'(y);
    enemy_x = 10'(ex);
    enemy_y = 9'(ey);
    bullet_act = 1'b1;
    k = cyc;
    kind = classify(x, y, ex, ey);
    if (!abort && kind != K_NONE)
      sb.push_back('{due: k + 3, tank: (kind == K_TANK),
                     explode: (kind == K_TANK || kind == K_WALL), x: x, y: y});
    repeat (hold) @(negedge clk25);
    bullet_act = 1'b0;
    repeat (26) @(negedge clk25);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_des"}, int'(des_bullet), 0);
    check({tag, "_hit"}, int'(hit_tank), 0);
    check({tag, "_flag"}, int'(explosion_flag), 0);
    check({tag, "_ex"}, int'(expl_x), 0);
    check({tag, "_ey"}, int'(expl_y), 0);
    check({tag, "_addr"}, int'(map_addr), 0);
  endtask

  task automatic reset_mid_expl();
    int k;
    @(negedge clk25);
    bullet_x = 10'd410;
    bullet_y = 9'd315;
    enemy_x = 10'd400;
    enemy_y = 9'd300;
    bullet_act = 1'b1;
    k = cyc;
    sb.push_back('{due: k + 3, tank: 1'b1, explode: 1'b1, x: 410, y: 315});
    repeat (4) @(negedge clk25);
    bullet_act = 1'b0;
    repeat (4) @(negedge clk25);
    check("pre_reset_expl", int'(explosion_flag), 1);
    #2 reset = 1'b1;
    #1 check_outputs_zero("async_rst");
    repeat (2) @(negedge clk25);
    #5 reset = 1'b0;
    repeat (4) @(negedge clk25);
  endtask

  initial begin
    int ex, ey, x, y, r;
    for (int i = 0; i < 512; i++) wall[i] = ($urandom_range(0, 3) == 0);
    wall[195] = 1'b0;
    wall[98] = 1'b1;
    wall[300] = 1'b1;
    #5 check_outputs_zero("reset");
    @(negedge clk25);
    #5 reset = 1'b0;
    repeat (3) @(negedge clk25);

    shot(100, 200, 400, 300, 10, 1'b0);  // no hit, several passes
    shot(410, 315, 400, 300, 4, 1'b0);   // tank (tile also wall: tank wins)
    shot(64, 96, 400, 300, 4, 1'b0);     // wall tile 0x62
    shot(1023, 100, 400, 300, 4, 1'b0);  // left wrap
    shot(100, 480, 400, 300, 4, 1'b0);   // bottom edge
    shot(640, 300, 630, 290, 4, 1'b0);   // out of bounds over tank
    shot(639, 479, 620, 460, 4, 1'b0);   // last on-screen pixel inside tank
    shot(431, 331, 400, 300, 4, 1'b0);   // far corner of box
    shot(432, 300, 400, 300, 4, 1'b0);   // one past box edge
    shot(399, 310, 400, 300, 4, 1'b0);   // one before box edge
    shot(410, 315, 400, 300, 1, 1'b1);   // drop in FETCH
    shot(410, 315, 400, 300, 2, 1'b1);   // drop in EVAL
    reset_mid_expl();
    shot(64, 96, 0, 0, 4, 1'b0);         // normal pass after reset

    for (int i = 0; i < 40; i++) begin
      ex = int'($urandom_range(0, 639));
      ey = int'($urandom_range(0, 479));
      r = int'($urandom_range(0, 5));
      case (r)
        0, 1: begin
          x = ex + int'($urandom_range(0, 31));
          y = ey + int'($urandom_range(0, 31));
        end
        2: begin
          x = int'($urandom_range(640, 1023));
          y = int'($urandom_range(0, 511));
        end
        3: begin
          x = int'($urandom_range(0, 639));
          y = int'($urandom_range(480, 511));
        end
        default: begin
          x = int'($urandom_range(0, 639));
          y = int'($urandom_range(0, 479));
        end
      endcase
      shot(x, y, ex, ey, int'($urandom_range(3, 8)), 1'b0);
    end

    repeat (10) @(negedge clk25);
    check("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
